// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl
//
// Frame scan controller feeding the pixel sampler. Walks an H_RES x V_RES
// frame in raster order and issues SPP sample requests per pixel on a
// registered valid/ready stream. Backpressure (out_valid & ~out_ready) is
// exported combinationally as the sampler stall.
//
// Configuration macro: PIXEL_SCAN_CONTINUOUS_EN
//   defined   : DONE returns straight to SCAN, so frames run back to back.
//   undefined : DONE returns to IDLE, and each frame needs a new start.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   begin a frame (only looked at in IDLE)
//   abort         in   synchronous abort, returns to IDLE
//   out_ready     in   downstream can accept a request
//   out_valid     out  request valid
//   pixel_x       out  column 0..H_RES-1
//   pixel_y       out  row 0..V_RES-1
//   sample_idx    out  sample 0..SPP-1
//   first_sample  out  sample_idx == 0
//   last_sample   out  sample_idx == SPP-1
//   last_of_frame out  last sample of the last pixel
//   stall         out  out_valid & ~out_ready
//   busy          out  state != IDLE
//   frame_done    out  one-cycle pulse per completed frame
//   frame_count   out  completed frames, wraps at 16 bits
module pixel_scan_ctrl #(
  parameter int H_RES = 800,
  parameter int V_RES = 600,
  parameter int SPP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [7:0]  sample_idx,
  output logic        first_sample,
  output logic        last_sample,
  output logic        last_of_frame,
  output logic        stall,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Flag values of the very first (0,0,0) request of a frame; they depend
  // only on the geometry, so degenerate sizes get the right flags at load.
  localparam logic LOAD_LAST = (SPP == 1);
  localparam logic LOAD_LOF  = (SPP == 1) && (H_RES == 1) && (V_RES == 1);

  state_t      state_q;
  logic        valid_q;
  logic [9:0]  x_q, y_q;
  logic [7:0]  s_q;
  logic        first_q, last_q, lof_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] count_q;

  // Next request after a handshake, with its flags precomputed so that the
  // flag outputs are registered together with the payload.
  logic        last_s, last_x, last_y;
  logic [9:0]  x_d, y_d;
  logic [7:0]  s_d;
  logic        first_d, last_d, lof_d;

  always_comb begin
    // Compare at 32-bit width so a parameter of 1024 / 256 never truncates.
    last_s  = (int'(s_q) == SPP - 1);
    last_x  = (int'(x_q) == H_RES - 1);
    last_y  = (int'(y_q) == V_RES - 1);
    s_d     = last_s ? 8'd0 : s_q + 8'd1;
    x_d     = x_q;
    y_d     = y_q;
    if (last_s) begin
      x_d = last_x ? 10'd0 : x_q + 10'd1;
      if (last_x) begin
        y_d = last_y ? 10'd0 : y_q + 10'd1;
      end
    end
    first_d = (s_d == 8'd0);
    last_d  = (int'(s_d) == SPP - 1);
    lof_d   = last_d && (int'(x_d) == H_RES - 1) && (int'(y_d) == V_RES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      lof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort wins over start and over a handshake in the same cycle.
        state_q <= IDLE;
        valid_q <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
        s_q     <= '0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        lof_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              x_q     <= '0;
              y_q     <= '0;
              s_q     <= '0;
              first_q <= 1'b1;
              last_q  <= LOAD_LAST;
              lof_q   <= LOAD_LOF;
            end
          end
          SCAN: begin
            // valid_q is always 1 here, so out_ready alone marks a handshake.
            if (out_ready) begin
              if (lof_q) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                s_q     <= '0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                lof_q   <= 1'b0;
                done_q  <= 1'b1;
                count_q <= count_q + 16'd1;
              end else begin
                x_q     <= x_d;
                y_q     <= y_d;
                s_q     <= s_d;
                first_q <= first_d;
                last_q  <= last_d;
                lof_q   <= lof_d;
              end
            end
          end
          DONE: begin
`ifdef PIXEL_SCAN_CONTINUOUS_EN
            state_q <= SCAN;
            valid_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            first_q <= 1'b1;
            last_q  <= LOAD_LAST;
            lof_q   <= LOAD_LOF;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid     = valid_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign sample_idx    = s_q;
  assign first_sample  = first_q;
  assign last_sample   = last_q;
  assign last_of_frame = lof_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_count   = count_q;
  // Combinational so the sampler sees backpressure in the same cycle.
  assign stall         = valid_q & ~out_ready;

endmodule
